// File: rtl/wb_stage_pkg.sv
// Shared CPU definitions for the write-back slice.
//   - Write-source select codes (in_wsel): WSEL_ALU, WSEL_MEM, WSEL_LINK.
//   - Load-operation codes (in_ldop): LDOP_LW..LDOP_LHU; 5-7 decode as lw.
//   - RESET_PC4: PC+4 of the text base, the PC4_W value after reset.
//   - wb_reg_t: the MEM/WB pipeline register fields.
package cpu_defs;

  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_MEM  = 2'd1;
  localparam logic [1:0] WSEL_LINK = 2'd2;

  localparam logic [2:0] LDOP_LW  = 3'd0;
  localparam logic [2:0] LDOP_LB  = 3'd1;
  localparam logic [2:0] LDOP_LBU = 3'd2;
  localparam logic [2:0] LDOP_LH  = 3'd3;
  localparam logic [2:0] LDOP_LHU = 3'd4;

  localparam logic [31:0] RESET_PC4 = 32'h0000_3004;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [4:0]  wa;
    logic        we;
    logic [1:0]  wsel;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [2:0]  ldop;
  } wb_reg_t;

endpackage

// File: rtl/wb_stage_load_ext.sv
// load_ext: combinational load-data alignment and extension.
// Ports:
//   mem      in  32  raw word read from data memory
//   addr     in  2   low bits of the load byte address
//   ldop     in  3   load operation (lw/lb/lbu/lh/lhu; 5-7 act as lw)
//   data     out 32  aligned, sign/zero-extended load result
//   misalign out 1   address not aligned to the access size (ungated)
module load_ext
  import cpu_defs::*;
(
  input  logic [31:0] mem,
  input  logic [1:0]  addr,
  input  logic [2:0]  ldop,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lanes: byte 0 is mem[7:0], half 0 is mem[15:0].
  assign byte_sel = mem[{addr, 3'b000} +: 8];
  assign half_sel = mem[{addr[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
    data     = mem;
    misalign = 1'b0;
    case (ldop)
      LDOP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LDOP_LBU: data = {24'h0, byte_sel};
      LDOP_LH: begin
        data     = {{16{half_sel[15]}}, half_sel};
        misalign = addr[0];
      end
      LDOP_LHU: begin
        data     = {16'h0, half_sel};
        misalign = addr[0];
      end
      default:  misalign = |addr;  // lw and the unused codes 5-7
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register plus write-back logic feeding the GRF
// write port, with a forwarding tap on the value being written.
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   stall_w, flush_w     hold the register / load a bubble (flush wins)
//   in_valid..in_ldop    MEM-stage instruction fields
//   WA, WD, GRFwe, PC4_W GRF write port driven from the register
//   fwd_valid            WA/WD are a live bypass source (== GRFwe)
//   misalign             load address not aligned to its access size
// Configuration: define WB_TRACE_EN to print every GRF write in simulation;
// the hardware is the same either way.
module wb_stage #(
  parameter int          DW        = 32,  // only 32 is supported
  parameter logic [31:0] RESET_PC4 = cpu_defs::RESET_PC4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall_w,
  input  logic          flush_w,
  input  logic          in_valid,
  input  logic [DW-1:0] in_pc4,
  input  logic [4:0]    in_wa,
  input  logic          in_we,
  input  logic [1:0]    in_wsel,
  input  logic [DW-1:0] in_alu,
  input  logic [DW-1:0] in_mem,
  input  logic [2:0]    in_ldop,
  output logic [4:0]    WA,
  output logic [DW-1:0] WD,
  output logic          GRFwe,
  output logic [DW-1:0] PC4_W,
  output logic          fwd_valid,
  output logic          misalign
);

  import cpu_defs::*;

  wb_reg_t     r;
  logic [31:0] ld_data;
  logic        ld_misalign;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r <= '{valid: 1'b0, pc4: RESET_PC4, wa: 5'd0, we: 1'b0, wsel: WSEL_ALU,
             alu: 32'd0, mem: 32'd0, ldop: LDOP_LW};
    end else if (flush_w) begin
      // Only the qualifiers are cleared; the payload of a bubble is never observed as a write.
      r.valid <= 1'b0;
      r.we    <= 1'b0;
    end else if (!stall_w) begin
      r <= '{valid: in_valid, pc4: in_pc4, wa: in_wa, we: in_we, wsel: in_wsel,
             alu: in_alu, mem: in_mem, ldop: in_ldop};
    end
  end

  load_ext u_load_ext (
    .mem      (r.mem),
    .addr     (r.alu[1:0]),
    .ldop     (r.ldop),
    .data     (ld_data),
    .misalign (ld_misalign)
  );

  // Alignment only matters for a live load that is actually written back.
  assign misalign = r.valid & r.we & (r.wsel == WSEL_MEM) & ld_misalign;

  always_comb begin
    WD = r.alu;  // WSEL_ALU and the reserved code 3
    case (r.wsel)
      WSEL_MEM:  WD = ld_data;
      WSEL_LINK: WD = r.pc4 + 32'd4;  // link value is PC+8
      default:   WD = r.alu;
    endcase
  end

  assign WA        = r.wa;
  assign PC4_W     = r.pc4;
  assign GRFwe     = r.valid & r.we & (r.wa != 5'd0) & ~misalign;
  assign fwd_valid = GRFwe;

`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (!reset && GRFwe) $display("@%h: $%d <= %h", PC4_W - 32'd4, WA, WD);
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall_w, flush_w, in_valid, in_we;
  logic [31:0] in_pc4, in_alu, in_mem;
  logic [4:0]  in_wa;
  logic [1:0]  in_wsel;
  logic [2:0]  in_ldop;
  logic [4:0]  WA;
  logic [31:0] WD, PC4_W;
  logic        GRFwe, fwd_valid, misalign;

  wb_stage dut (
    .clk(clk), .reset(reset), .stall_w(stall_w), .flush_w(flush_w),
    .in_valid(in_valid), .in_pc4(in_pc4), .in_wa(in_wa), .in_we(in_we),
    .in_wsel(in_wsel), .in_alu(in_alu), .in_mem(in_mem), .in_ldop(in_ldop),
    .WA(WA), .WD(WD), .GRFwe(GRFwe), .PC4_W(PC4_W),
    .fwd_valid(fwd_valid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, stall, flush, valid, we;
    bit [31:0] pc4, alu, mem;
    bit [4:0]  wa;
    bit [1:0]  wsel;
    bit [2:0]  ldop;
  } stim_t;

  typedef struct {
    bit        we, mis, full;
    bit [4:0]  wa;
    bit [31:0] wd, pc4;
  } exp_t;

  exp_t  sb_q[$];
  stim_t held;       // instruction the model believes is in the WB stage
  bit    held_full;  // payload fields are defined (not after a flush)
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: write-back result of one instruction straight from the ISA rules.
  function automatic exp_t predict(input stim_t s, input bit full);
    exp_t e;
    int unsigned off, b, h;
    bit [31:0] load;
    bit is_half, is_word;
    off = s.alu % 4;
    b = (s.mem >> (8 * off)) % 256;
    h = (s.mem >> (16 * (off / 2))) % 65536;
    is_half = (s.ldop == 3 || s.ldop == 4);
    is_word = !(s.ldop >= 1 && s.ldop <= 4);
    case (s.ldop)
      1:       load = (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      2:       load = 32'(b);
      3:       load = (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      4:       load = 32'(h);
      default: load = s.mem;
    endcase
    e.mis  = s.valid && s.we && s.wsel == 1 &&
             ((is_half && off % 2 == 1) || (is_word && off != 0));
    e.wd   = (s.wsel == 1) ? load : (s.wsel == 2) ? s.pc4 + 4 : s.alu;
    e.we   = s.valid && s.we && s.wa != 0 && !e.mis;
    e.wa   = s.wa;
    e.pc4  = s.pc4;
    e.full = full;
    return e;
  endfunction

  task automatic step(input stim_t s);
    reset = s.rst; stall_w = s.stall; flush_w = s.flush;
    in_valid = s.valid; in_we = s.we; in_pc4 = s.pc4; in_wa = s.wa;
    in_wsel = s.wsel; in_alu = s.alu; in_mem = s.mem; in_ldop = s.ldop;
    @(posedge clk);
    if (s.rst) begin
      held = '{default: 0};
      held.pc4 = 32'h0000_3004;
      held_full = 1;
    end else if (s.flush) begin
      held.valid = 0; held.we = 0; held_full = 0;
    end else if (!s.stall) begin
      held = s; held_full = 1;
    end
    sb_q.push_back(predict(held, held_full));
    #1;
  endtask

  function automatic stim_t instr(input bit [4:0] wa, input bit [1:0] wsel, input bit [2:0] ldop,
                                  input bit [31:0] alu, input bit [31:0] mem, input bit [31:0] pc4);
    stim_t s = '{default: 0};
    s.valid = 1; s.we = 1; s.wa = wa; s.wsel = wsel; s.ldop = ldop;
    s.alu = alu; s.mem = mem; s.pc4 = pc4;
    return s;
  endfunction

  // Monitor: one registered result per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("GRFwe", 32'(GRFwe), 32'(e.we));
        check("fwd_valid", 32'(fwd_valid), 32'(e.we));
        check("misalign", 32'(misalign), 32'(e.mis));
        if (e.full) begin
          check("WA", 32'(WA), 32'(e.wa));
          check("WD", WD, e.wd);
          check("PC4_W", PC4_W, e.pc4);
        end
      end
    end
  end

  initial begin
    stim_t s;
    stim_t r = '{default: 0};
    r.rst = 1;
    step(r); step(r);
    check("reset_PC4_W", PC4_W, 32'h0000_3004);
    check("reset_WD", WD, 32'h0);

    step(instr(5'd8, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h3008));
    check("alu_WD", WD, 32'h1234_5678);
    step(instr(5'd9, 2'd1, 3'd1, 32'h0000_1002, 32'h80FF_7F01, 32'h300C));
    check("lb_WD", WD, 32'hFFFF_FFFF);
    step(instr(5'd9, 2'd1, 3'd2, 32'h0000_1002, 32'h80FF_7F01, 32'h300C));
    check("lbu_WD", WD, 32'h0000_00FF);
    step(instr(5'd9, 2'd1, 3'd3, 32'h0000_1002, 32'h80FF_7F01, 32'h300C));
    check("lh_WD", WD, 32'hFFFF_80FF);
    step(instr(5'd9, 2'd1, 3'd3, 32'h0000_1001, 32'h80FF_7F01, 32'h300C));
    check("lh_mis", 32'(misalign), 32'd1);
    step(instr(5'd0, 2'd0, 3'd0, 32'h0000_00AA, 32'h0, 32'h3010));
    check("zero_we", 32'(GRFwe), 32'd0);
    step(instr(5'd31, 2'd2, 3'd0, 32'h0, 32'h0, 32'h3010));
    check("link_WD", WD, 32'h3014);

    // Stall three cycles on a misaligned load, then stall+flush, then reset mid-stall.
    step(instr(5'd4, 2'd1, 3'd0, 32'h0000_2002, 32'hDEAD_BEEF, 32'h3020));
    s = instr(5'd5, 2'd0, 3'd0, 32'h1, 32'h0, 32'h3024);
    s.stall = 1;
    repeat (3) step(s);
    s.flush = 1;
    step(s);
    s.flush = 0;
    step(instr(5'd6, 2'd0, 3'd0, 32'h77, 32'h0, 32'h3028));
    step(s);
    s.rst = 1;
    step(s);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      s.rst   = ($urandom_range(0, 49) == 0);
      s.stall = ($urandom_range(0, 4) == 0);
      s.flush = ($urandom_range(0, 9) == 0);
      s.valid = ($urandom_range(0, 7) != 0);
      s.we    = ($urandom_range(0, 5) != 0);
      s.wa    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      s.wsel  = 2'($urandom);
      s.ldop  = 3'($urandom);
      s.alu   = $urandom;
      s.mem   = $urandom;
      s.pc4   = {$urandom, 2'b00} + 32'h3004;
      step(s);
    end

    s = '{default: 0};
    step(s);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
